// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared LSU opcodes, bus sizing, FSM encoding and op classifiers
package mem_lsu_pkg;

    localparam int DataMemNumLog2 = 10;
    localparam int DmAddrW        = DataMemNumLog2 + 2;

    localparam logic [4:0] ALU_LB  = 5'h10;
    localparam logic [4:0] ALU_LH  = 5'h11;
    localparam logic [4:0] ALU_LW  = 5'h12;
    localparam logic [4:0] ALU_LBU = 5'h13;
    localparam logic [4:0] ALU_LHU = 5'h14;
    localparam logic [4:0] ALU_SB  = 5'h15;
    localparam logic [4:0] ALU_SH  = 5'h16;
    localparam logic [4:0] ALU_SW  = 5'h17;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    function automatic logic is_load(input logic [4:0] op);
        return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
               (op == ALU_LBU) || (op == ALU_LHU);
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

    // Halfword accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [4:0] op, input logic [1:0] addr_lo);
        return (((op == ALU_LH) || (op == ALU_LHU) || (op == ALU_SH)) && addr_lo[0]) ||
               (((op == ALU_LW) || (op == ALU_SW)) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering: store byte enables/replication and load extraction/extension
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [4:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Pick the addressed byte and halfword out of the returned word.
    always_comb begin
        ld_byte = ld_raw[7:0];
        case (addr_lo)
            2'd0: ld_byte = ld_raw[7:0];
            2'd1: ld_byte = ld_raw[15:8];
            2'd2: ld_byte = ld_raw[23:16];
            2'd3: ld_byte = ld_raw[31:24];
            default: ld_byte = ld_raw[7:0];
        endcase
        ld_half = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    end

    // Sign/zero extend; a word load always uses the whole lane-0 word.
    always_comb begin
        ld_data = ld_raw;
        case (aluop)
            ALU_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            ALU_LBU: ld_data = {24'h000000, ld_byte};
            ALU_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            ALU_LHU: ld_data = {16'h0000, ld_half};
            default: ld_data = ld_raw;
        endcase
    end

    // Replicate store data across all lanes and enable only the addressed ones.
    always_comb begin
        be    = 4'b0000;
        wdata = st_data;
        case (aluop)
            ALU_SB: begin
                be    = BE_BYTE0 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            ALU_SH: begin
                be    = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata = {2{st_data[15:0]}};
            end
            ALU_SW: begin
                be    = BE_WORD;
                wdata = st_data;
            end
            default: begin
                be    = 4'b0000;
                wdata = st_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with req/gnt/rvalid data bus; option MEM_LSU_MISALIGN_CHECK_EN
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,

    input  logic               mem_wreg_i,
    input  logic [4:0]         mem_rd_addr_i,
    input  logic [31:0]        mem_rd_data_i,
    input  logic [4:0]         mem_aluop_i,
    input  logic [DmAddrW-1:0] mem_mem_addr_i,
    input  logic [31:0]        mem_rs2_i,
    input  logic               mem_stall_i,

    output logic               wb_wreg_o,
    output logic [4:0]         wb_rd_addr_o,
    output logic [31:0]        wb_rd_data_o,
    output logic               stallreq_o,

    output logic               dm_req_o,
    output logic               dm_we_o,
    output logic [DmAddrW-1:0] dm_addr_o,
    output logic [3:0]         dm_be_o,
    output logic [31:0]        dm_wdata_o,
    input  logic               dm_gnt_i,
    input  logic               dm_rvalid_i,
    input  logic [31:0]        dm_rdata_i
`ifdef MEM_LSU_MISALIGN_CHECK_EN
    ,
    output logic               misalign_o
`endif
);

    lsu_state_e  state_q, state_d;
    logic [31:0] cap_q;
    logic        cap_en;
    logic        req;
    logic        stall;
    logic [31:0] wb_data;

    logic        op_ld;
    logic        op_st;
    logic        misalign;
    logic        mem_op;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ld;

    assign op_ld = is_load(mem_aluop_i);
    assign op_st = is_store(mem_aluop_i);

`ifdef MEM_LSU_MISALIGN_CHECK_EN
    assign misalign   = is_misaligned(mem_aluop_i, mem_mem_addr_i[1:0]);
    assign misalign_o = misalign;
`else
    assign misalign   = 1'b0;
`endif

    // A misaligned access is squashed: it never reaches the bus and never writes back.
    assign mem_op = (op_ld | op_st) & ~misalign;

    lsu_align u_align (
        .aluop   (mem_aluop_i),
        .addr_lo (mem_mem_addr_i[1:0]),
        .st_data (mem_rs2_i),
        .ld_raw  (dm_rdata_i),
        .be      (al_be),
        .wdata   (al_wdata),
        .ld_data (al_ld)
    );

    // Access sequencing: request until granted, wait for load data, then park in
    // DONE while the pipeline is still held so the access is never reissued.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        cap_en  = 1'b0;
        wb_data = op_ld ? cap_q : mem_rd_data_i;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        req     = 1'b1;
                        stall   = 1'b1;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    req   = 1'b1;
                    stall = 1'b1;
                    if (dm_gnt_i) begin
                        if (op_st) begin
                            stall   = 1'b0;
                            state_d = mem_stall_i ? DONE : IDLE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    stall = 1'b1;
                    if (dm_rvalid_i) begin
                        stall   = 1'b0;
                        cap_en  = 1'b1;
                        wb_data = al_ld;
                        state_d = mem_stall_i ? DONE : IDLE;
                    end
                end
                DONE: begin
                    if (!mem_stall_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holds the extended load result for replay while the pipeline stays stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= 32'h0000_0000;
        end else if (cap_en) begin
            cap_q <= al_ld;
        end
    end

    assign stallreq_o   = stall;
    assign dm_req_o     = req;
    assign dm_we_o      = req & op_st;
    assign dm_addr_o    = req ? {mem_mem_addr_i[DmAddrW-1:2], 2'b00} : '0;
    assign dm_be_o      = (req & op_st) ? al_be : 4'b0000;
    assign dm_wdata_o   = (req & op_st) ? al_wdata : 32'h0000_0000;

    assign wb_wreg_o    = mem_wreg_i & ~op_st & ~misalign;
    assign wb_rd_addr_o = mem_rd_addr_i;
    assign wb_rd_data_o = wb_data;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed bench for mem_lsu with a cycle model and literal anchors; option MEM_LSU_MISALIGN_CHECK_EN
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam logic [4:0] OP_ADD = 5'h01;

    logic               clk;
    logic               rst;
    logic               mem_wreg_i;
    logic [4:0]         mem_rd_addr_i;
    logic [31:0]        mem_rd_data_i;
    logic [4:0]         mem_aluop_i;
    logic [DmAddrW-1:0] mem_mem_addr_i;
    logic [31:0]        mem_rs2_i;
    logic               mem_stall_i;
    logic               wb_wreg_o;
    logic [4:0]         wb_rd_addr_o;
    logic [31:0]        wb_rd_data_o;
    logic               stallreq_o;
    logic               dm_req_o;
    logic               dm_we_o;
    logic [DmAddrW-1:0] dm_addr_o;
    logic [3:0]         dm_be_o;
    logic [31:0]        dm_wdata_o;
    logic               dm_gnt_i;
    logic               dm_rvalid_i;
    logic [31:0]        dm_rdata_i;
`ifdef MEM_LSU_MISALIGN_CHECK_EN
    logic               misalign_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic               cmp_en;
    logic               exp_stall, exp_req, exp_st, exp_wreg, exp_wb_chk, exp_mis;
    logic [DmAddrW-1:0] exp_addr;
    logic [3:0]         exp_be;
    logic [31:0]        exp_wdata, exp_wb;
    logic [4:0]         exp_rd;

    mem_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .mem_wreg_i     (mem_wreg_i),
        .mem_rd_addr_i  (mem_rd_addr_i),
        .mem_rd_data_i  (mem_rd_data_i),
        .mem_aluop_i    (mem_aluop_i),
        .mem_mem_addr_i (mem_mem_addr_i),
        .mem_rs2_i      (mem_rs2_i),
        .mem_stall_i    (mem_stall_i),
        .wb_wreg_o      (wb_wreg_o),
        .wb_rd_addr_o   (wb_rd_addr_o),
        .wb_rd_data_o   (wb_rd_data_o),
        .stallreq_o     (stallreq_o),
        .dm_req_o       (dm_req_o),
        .dm_we_o        (dm_we_o),
        .dm_addr_o      (dm_addr_o),
        .dm_be_o        (dm_be_o),
        .dm_wdata_o     (dm_wdata_o),
        .dm_gnt_i       (dm_gnt_i),
        .dm_rvalid_i    (dm_rvalid_i),
        .dm_rdata_i     (dm_rdata_i)
`ifdef MEM_LSU_MISALIGN_CHECK_EN
        ,
        .misalign_o     (misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_is_load(input logic [4:0] op);
        return op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    endfunction

    // Load result from the raw bus word by shifting the addressed lane down.
    function automatic logic [31:0] m_load(input logic [4:0] op, input logic [1:0] lo, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * int'(lo))) & 32'h0000_00FF;
        h = (rd >> (16 * int'(lo[1]))) & 32'h0000_FFFF;
        case (op)
            ALU_LB:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            ALU_LBU: return b;
            ALU_LH:  return h[15] ? (h | 32'hFFFF_0000) : h;
            ALU_LHU: return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [4:0] op, input logic [1:0] lo);
        case (op)
            ALU_SB:  return 4'b0001 << lo;
            ALU_SH:  return 4'b0011 << (2 * int'(lo[1]));
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [4:0] op, input logic [31:0] rs2);
        case (op)
            ALU_SB:  return {24'h0, rs2[7:0]} * 32'h0101_0101;
            ALU_SH:  return {16'h0, rs2[15:0]} * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    // Single compare process: every enabled cycle, DUT outputs versus the model's expectations.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("stallreq_o", 32'(stallreq_o), 32'(exp_stall));
            check("dm_req_o", 32'(dm_req_o), 32'(exp_req));
            if (exp_req) begin
                check("dm_we_o", 32'(dm_we_o), 32'(exp_st));
                check("dm_addr_o", 32'(dm_addr_o), 32'(exp_addr));
                if (exp_st) begin
                    check("dm_be_o", 32'(dm_be_o), 32'(exp_be));
                    check("dm_wdata_o", dm_wdata_o, exp_wdata);
                end
            end
            check("wb_wreg_o", 32'(wb_wreg_o), 32'(exp_wreg));
            if (!exp_st) check("wb_rd_addr_o", 32'(wb_rd_addr_o), 32'(exp_rd));
            if (exp_wb_chk) check("wb_rd_data_o", wb_rd_data_o, exp_wb);
`ifdef MEM_LSU_MISALIGN_CHECK_EN
            check("misalign_o", 32'(misalign_o), 32'(exp_mis));
`endif
        end
    end

    // One cycle of a non-memory op: everything passes straight through.
    task automatic run_nop();
        @(posedge clk); #1;
        mem_aluop_i    = OP_ADD;
        mem_mem_addr_i = DmAddrW'($urandom);
        mem_rs2_i      = $urandom;
        mem_wreg_i     = 1'($urandom);
        mem_rd_addr_i  = 5'($urandom);
        mem_rd_data_i  = $urandom;
        mem_stall_i    = 1'b0;
        dm_gnt_i       = 1'b0;
        dm_rvalid_i    = 1'b0;
        dm_rdata_i     = 32'h5A5A_5A5A;
        exp_stall = 1'b0; exp_req = 1'b0; exp_st = 1'b0; exp_mis = 1'b0;
        exp_wreg  = mem_wreg_i; exp_rd = mem_rd_addr_i;
        exp_wb_chk = 1'b1; exp_wb = mem_rd_data_i;
        cmp_en = 1'b1;
    endtask

    // One memory op: gnt in cycle gnt_c, load data in cycle rv_c, then mem_stall_i held
    // for 'hold' extra cycles after completion. Literal anchors are checked along the way.
    task automatic run_op(input logic [4:0] op, input int addr, input logic [31:0] rs2,
                          input logic [31:0] rdata, input int gnt_c, input int rv_c, input int hold,
                          input logic [31:0] lit_val, input logic [3:0] lit_be, input int lit_addr,
                          input int lit_stall, input int lit_req);
        logic        ld;
        int          done_c, total, nstall, nreq;
        logic [4:0]  rd;
        logic [31:0] alu;
        ld     = m_is_load(op);
        done_c = ld ? rv_c : gnt_c;
        total  = done_c + 1 + hold;
        nstall = 0;
        nreq   = 0;
        rd     = 5'($urandom_range(31, 1));
        alu    = $urandom;
        for (int c = 0; c < total; c++) begin
            @(posedge clk); #1;
            mem_aluop_i    = op;
            mem_mem_addr_i = DmAddrW'(addr);
            mem_rs2_i      = rs2;
            mem_wreg_i     = 1'b1;
            mem_rd_addr_i  = rd;
            mem_rd_data_i  = alu;
            mem_stall_i    = (c < done_c + hold);
            dm_gnt_i       = (c == gnt_c);
            dm_rvalid_i    = ld && (c == rv_c);
            dm_rdata_i     = dm_rvalid_i ? rdata : 32'h5A5A_5A5A;
            exp_stall  = (c < done_c);
            exp_req    = (c <= gnt_c);
            exp_st     = !ld;
            exp_mis    = 1'b0;
            exp_addr   = DmAddrW'(addr & ~3);
            exp_be     = m_be(op, 2'(addr));
            exp_wdata  = m_wdata(op, rs2);
            exp_wreg   = ld;
            exp_rd     = rd;
            exp_wb_chk = ld && (c >= done_c);
            exp_wb     = m_load(op, 2'(addr), rdata);
            cmp_en     = 1'b1;
            @(negedge clk);
            if (stallreq_o) nstall++;
            if (dm_req_o) nreq++;
            if (c == gnt_c) check("lit_dm_addr", 32'(dm_addr_o), 32'(lit_addr));
            if (c == gnt_c && !ld) begin
                check("lit_dm_be", 32'(dm_be_o), 32'(lit_be));
                check("lit_dm_wdata", dm_wdata_o, lit_val);
            end
            if (c == done_c && ld) check("lit_wb_load", wb_rd_data_o, lit_val);
        end
        check("lit_stall_cycles", 32'(nstall), 32'(lit_stall));
        check("lit_req_cycles", 32'(nreq), 32'(lit_req));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cmp_en = 1'b0;
        rst = 1'b1;
        mem_wreg_i = 1'b0; mem_rd_addr_i = 5'd0; mem_rd_data_i = 32'h0; mem_aluop_i = OP_ADD;
        mem_mem_addr_i = '0; mem_rs2_i = 32'h0; mem_stall_i = 1'b0;
        dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0; dm_rdata_i = 32'h0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_st = 1'b0; exp_wreg = 1'b0; exp_wb_chk = 1'b0;
        exp_mis = 1'b0; exp_addr = '0; exp_be = 4'h0; exp_wdata = 32'h0; exp_wb = 32'h0; exp_rd = 5'd0;

        // Reset state, including a load waiting at the inputs.
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_stallreq", 32'(stallreq_o), 32'd0);
        check("rst_dm_req", 32'(dm_req_o), 32'd0);
        mem_aluop_i = ALU_LW; mem_mem_addr_i = DmAddrW'(8);
        #1;
        check("rst_lw_dm_req", 32'(dm_req_o), 32'd0);
        check("rst_lw_stallreq", 32'(stallreq_o), 32'd0);
        @(posedge clk); #1;
        mem_aluop_i = OP_ADD;
        rst = 1'b0;

        run_nop();
        //      op       addr  rs2           rdata         gnt rv hold lit_val       be     addr  stl req
        run_op(ALU_LW,  'h08, 32'h0,        32'hDEADBEEF, 1,  3, 0,   32'hDEADBEEF, 4'h0, 'h08, 3, 2); run_nop();
        run_op(ALU_LB,  'h03, 32'h0,        32'h80123456, 1,  2, 0,   32'hFFFFFF80, 4'h0, 'h00, 2, 2); run_nop();
        run_op(ALU_LBU, 'h03, 32'h0,        32'h80123456, 1,  2, 0,   32'h00000080, 4'h0, 'h00, 2, 2); run_nop();
        run_op(ALU_LHU, 'h02, 32'h0,        32'h80015555, 2,  4, 0,   32'h00008001, 4'h0, 'h00, 4, 3); run_nop();
        run_op(ALU_LH,  'h10, 32'h0,        32'h1234F00D, 1,  2, 0,   32'hFFFFF00D, 4'h0, 'h10, 2, 2); run_nop();
        run_op(ALU_LB,  'h21, 32'h0,        32'h00007F00, 1,  2, 0,   32'h0000007F, 4'h0, 'h20, 2, 2); run_nop();
        run_op(ALU_LHU, 'h06, 32'h0,        32'hA5A5C3C3, 1,  3, 0,   32'h0000A5A5, 4'h0, 'h04, 3, 2); run_nop();
        run_op(ALU_SH,  'h06, 32'h1234ABCD, 32'h0,        2,  0, 0,   32'hABCDABCD, 4'hC, 'h04, 2, 3); run_nop();
        run_op(ALU_SB,  'h05, 32'h000000EF, 32'h0,        1,  0, 0,   32'hEFEFEFEF, 4'h2, 'h04, 1, 2); run_nop();
        run_op(ALU_SW,  'h0C, 32'hCAFEF00D, 32'h0,        1,  0, 1,   32'hCAFEF00D, 4'hF, 'h0C, 1, 2); run_nop();
        run_op(ALU_SB,  'h13, 32'h556677AB, 32'h0,        3,  0, 0,   32'hABABABAB, 4'h8, 'h10, 3, 4); run_nop();
        // Load completes while the pipeline stays held: replay, no second request.
        run_op(ALU_LW,  'h40, 32'h0,        32'h13579BDF, 1,  2, 2,   32'h13579BDF, 4'h0, 'h40, 2, 2); run_nop();
`ifndef MEM_LSU_MISALIGN_CHECK_EN
        // Low address bits below the access size are ignored.
        run_op(ALU_LW,  'h0B, 32'h0,        32'h11223344, 1,  2, 0,   32'h11223344, 4'h0, 'h08, 2, 2); run_nop();
        run_op(ALU_LH,  'h03, 32'h0,        32'h87654321, 1,  2, 0,   32'hFFFF8765, 4'h0, 'h00, 2, 2); run_nop();
`else
        // Misaligned accesses are squashed in the same cycle.
        @(posedge clk); #1;
        mem_aluop_i = ALU_SW; mem_mem_addr_i = DmAddrW'('h05); mem_rs2_i = 32'h01020304;
        mem_wreg_i = 1'b1; mem_stall_i = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_st = 1'b1; exp_wreg = 1'b0; exp_wb_chk = 1'b0; exp_mis = 1'b1;
        @(negedge clk);
        check("lit_mis_sw", 32'(misalign_o), 32'd1);
        check("lit_mis_sw_req", 32'(dm_req_o), 32'd0);
        check("lit_mis_sw_stall", 32'(stallreq_o), 32'd0);
        @(posedge clk); #1;
        mem_aluop_i = ALU_LH; mem_mem_addr_i = DmAddrW'('h01);
        exp_st = 1'b0; exp_rd = mem_rd_addr_i;
        @(negedge clk);
        check("lit_mis_lh_wreg", 32'(wb_wreg_o), 32'd0);
        run_nop();
`endif

        // Reset while waiting for load data, then a stray rvalid from the abandoned access.
        cmp_en = 1'b0;
        @(posedge clk); #1;
        mem_aluop_i = ALU_LW; mem_mem_addr_i = DmAddrW'('h10); mem_wreg_i = 1'b1; mem_stall_i = 1'b1;
        dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0;
        @(posedge clk); #1;
        dm_gnt_i = 1'b1;
        @(posedge clk); #1;
        dm_gnt_i = 1'b0;
        @(negedge clk);
        check("wait_stallreq", 32'(stallreq_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midwait_rst_dm_req", 32'(dm_req_o), 32'd0);
        check("midwait_rst_stallreq", 32'(stallreq_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_aluop_i = OP_ADD; mem_rd_data_i = 32'h11112222; mem_stall_i = 1'b0;
        dm_rvalid_i = 1'b1; dm_rdata_i = 32'hBAADF00D;
        @(negedge clk);
        check("stray_rvalid_wb", wb_rd_data_o, 32'h11112222);
        check("stray_rvalid_stallreq", 32'(stallreq_o), 32'd0);
        check("stray_rvalid_dm_req", 32'(dm_req_o), 32'd0);
        @(posedge clk); #1;
        dm_rvalid_i = 1'b0;
        run_op(ALU_LW, 'h10, 32'h0, 32'h0F0F0F0F, 1, 2, 1, 32'h0F0F0F0F, 4'h0, 'h10, 2, 2);
        run_nop();

        @(posedge clk); #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL take the EX/MEM side as inputs: mem_wreg_i 1; mem_rd_addr_i 5; mem_rd_data_i 32 (ALU result); mem_aluop_i 5; mem_mem_addr_i DataMemNumLog2+2 (byte address); mem_rs2_i 32 (store data).
REQ-003 SHALL take mem_stall_i  in  1: the MEM-stage hold bit from the control block (stall[4]).
REQ-004 SHALL drive the MEM/WB side: wb_wreg_o 1; wb_rd_addr_o 5; wb_rd_data_o 32.
REQ-005 SHALL drive stallreq_o  out  1: MEM-stage stall request to the control block.
REQ-006 SHALL drive the data-memory bus outputs: dm_req_o 1; dm_we_o 1; dm_addr_o DataMemNumLog2+2 (word-aligned, bits[1:0]=0); dm_be_o 4; dm_wdata_o 32.
REQ-007 SHALL take the data-memory bus inputs: dm_gnt_i 1 (request accepted); dm_rvalid_i 1 (read data valid); dm_rdata_i 32.

Function
REQ-008 SHALL recognise LB, LH, LW, LBU, LHU, SB, SH and SW by aluop; all other aluops are non-memory ops.
REQ-009 SHALL pass non-memory ops through combinationally: wb_* = mem_*_i, stallreq_o=0, no bus request.
REQ-010 SHALL use FSM states IDLE, REQ, WAIT and DONE.
REQ-011 IDLE with a memory op: SHALL assert dm_req_o and stallreq_o in the same cycle and go to REQ.
REQ-012 REQ: SHALL hold dm_req_o, dm_we_o, dm_addr_o, dm_be_o and dm_wdata_o stable until dm_gnt_i=1.
REQ-013 REQ, gnt on a store: SHALL deassert stallreq_o in that cycle and go to DONE if mem_stall_i=1, else IDLE.
REQ-014 REQ, gnt on a load: SHALL go to WAIT; dm_rvalid_i is valid no earlier than the cycle after gnt.
REQ-015 WAIT: SHALL hold stallreq_o=1 until dm_rvalid_i=1.
REQ-016 WAIT, rvalid cycle: SHALL drive wb_rd_data_o with the extended load data, deassert stallreq_o, capture that data, then go to DONE if mem_stall_i=1, else IDLE.
REQ-017 DONE: SHALL replay the captured result, issue no bus request, keep stallreq_o=0, and return to IDLE when mem_stall_i=0; no access is ever issued twice.
REQ-018 Stores SHALL use: SB be=1<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}; SW be=4'b1111, wdata=rs2.
REQ-019 Loads SHALL select the lane by addr[1:0] (bytes) or addr[1] (halves); LB/LH sign-extend; LBU/LHU zero-extend.
REQ-020 Stores SHALL force wb_wreg_o=0; loads SHALL pass mem_wreg_i and mem_rd_addr_i through.

Reset
REQ-021 Asserting rst SHALL immediately clear the FSM to IDLE, dm_req_o=0, stallreq_o=0 and the capture register to 0, including mid-REQ or mid-WAIT.
REQ-022 After reset, SHALL ignore a dm_rvalid_i that belongs to an abandoned access.

Configuration
REQ-023 With MEM_LSU_MISALIGN_CHECK_EN defined: SHALL add misalign_o  out  1, asserted combinationally for LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0; no bus request; stallreq_o=0; wb_wreg_o=0.
REQ-024 Without MEM_LSU_MISALIGN_CHECK_EN: SHALL have no misalign_o port; SHALL ignore the low address bits below the access size (halfword uses addr[1], word uses lane 0).

Structure
REQ-025 The load/store aluop codes, the FSM state encoding and DataMemNumLog2 SHALL live in the shared define package; no literals are duplicated in the module.
REQ-026 The lane select and sign/zero extension SHALL be one combinational sub-module, lsu_align, reused for the store lane/be generation.

Verification
REQ-027 LW addr 0x08, gnt in cycle 1, rvalid in cycle 3 with rdata 0xDEADBEEF -> stallreq_o high in cycles 0-2, low in cycle 3; wb_rd_data_o=0xDEADBEEF in cycle 3.
REQ-028 LB addr 0x03, rdata 0x80123456 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x02, rdata 0x8001xxxx -> 0x00008001.
REQ-029 SH addr 0x06, rs2 0x1234ABCD, gnt delayed 2 cycles -> dm_be_o=4'b1100, dm_wdata_o=0xABCDABCD held 3 cycles, dm_addr_o=0x04, wb_wreg_o=0.
REQ-030 LW completes with mem_stall_i held 2 more cycles -> state DONE, no second dm_req_o, wb_rd_data_o stable.
REQ-031 rst pulse mid-WAIT, then a stray dm_rvalid_i -> dm_req_o=0 and stallreq_o=0 at once, FSM IDLE, stray data discarded.
REQ-032 With MEM_LSU_MISALIGN_CHECK_EN defined: SW addr 0x05 -> misalign_o=1, dm_req_o=0, stallreq_o=0.
